// File: rtl/svn_pkg.sv
// svn_pkg: shared constants and helpers for the seven-segment scan controller.
//   - SEG_0 .. SEG_F : active-low {CA,CB,CC,CD,CE,CF,CG} glyph patterns
//                      (bit 6 = CA, bit 0 = CG)
//   - SEG_OFF        : all segments dark
//   - presc_width()  : prescaler counter width, never below 1 bit
//   - idx_width()    : digit index width, never below 1 bit
package svn_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int presc_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/svn_scan_ctrl_if.sv
// svn_scan_ctrl_if: user-logic side of the scan controller.
//   data[4*NUM_DIGITS]  hex nibble per digit, digit i = data[4i+3:4i]
//   dp[NUM_DIGITS]      decimal point per digit, 1 = lit
//   digit_en[NUM_DIGITS] 1 = digit shown, 0 = blanked
//   load                1-cycle strobe capturing data/dp/digit_en
//   frame_done          1-cycle pulse after the scan wraps to digit 0
// master = user logic, slave = svn_scan_ctrl.
interface svn_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    frame_done;

  modport master (output data, dp, digit_en, load, input frame_done);
  modport slave  (input data, dp, digit_en, load, output frame_done);
endinterface

// File: rtl/svn_hex_lut.sv
// svn_hex_lut: combinational hex nibble to active-low seven-segment pattern.
//   nibble[4]  value to display
//   seg[7]     {CA,CB,CC,CD,CE,CF,CG}, 0 = segment lit
module svn_hex_lut
  import svn_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/svn_scan_ctrl.sv
// svn_scan_ctrl: multiplexed common-anode seven-segment display controller.
//   clk        system clock
//   sys_rst_n  asynchronous active-low reset
//   bright[4]  (only with SVN_SCAN_BRIGHTNESS_EN) anode duty, (bright+1)/16
//   bus        svn_scan_ctrl_if.slave: data/dp/digit_en/load in, frame_done out
//   CA..CG     segment cathodes, active-low
//   DP         decimal point cathode, active-low
//   AN         digit anodes, active-low, at most one low
// Each digit stays selected for CLK_DIV clocks. New values go to a staging
// buffer and are only copied to the displayed (active) buffer when the scan
// wraps back to digit 0, so a frame never mixes old and new values.
// Optional feature macro: SVN_SCAN_BRIGHTNESS_EN.
module svn_scan_ctrl
  import svn_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
`ifdef SVN_SCAN_BRIGHTNESS_EN
  input  logic [3:0]            bright,
`endif
  svn_scan_ctrl_if.slave        bus,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN
);

  localparam int PW = presc_width(CLK_DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_reg;
  logic [IW-1:0]           idx_reg;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] stg_data_reg, act_data_reg;
  logic [NUM_DIGITS-1:0]   stg_dp_reg,   act_dp_reg;
  logic [NUM_DIGITS-1:0]   stg_en_reg,   act_en_reg;
  logic                    pending_reg;

  logic [3:0]              sel_nibble;
  logic                    sel_en;
  logic                    sel_dp;
  logic [6:0]              lut_seg;
  logic                    pwm_on;

  logic [6:0]              seg_reg;
  logic                    dp_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    frame_done_reg;

  assign tick = (presc_reg == PRESC_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);

  // Prescaler and digit index
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (tick) begin
      presc_reg <= '0;
      idx_reg   <= wrap ? '0 : idx_reg + IW'(1);
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Double buffer. On a wrap the active copy takes the staging contents as
  // they were before this edge, so a load landing on the boundary stays
  // pending for the next frame.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stg_data_reg <= '0;
      stg_dp_reg   <= '0;
      stg_en_reg   <= '0;
      act_data_reg <= '0;
      act_dp_reg   <= '0;
      act_en_reg   <= '0;
      pending_reg  <= 1'b0;
    end else begin
      if (wrap && pending_reg) begin
        act_data_reg <= stg_data_reg;
        act_dp_reg   <= stg_dp_reg;
        act_en_reg   <= stg_en_reg;
      end
      if (bus.load) begin
        stg_data_reg <= bus.data;
        stg_dp_reg   <= bus.dp;
        stg_en_reg   <= bus.digit_en;
        pending_reg  <= 1'b1;
      end else if (wrap) begin
        pending_reg  <= 1'b0;
      end
    end
  end

  assign sel_nibble = act_data_reg[{idx_reg, 2'b00} +: 4];
  assign sel_en     = act_en_reg[idx_reg];
  assign sel_dp     = act_dp_reg[idx_reg];

  svn_hex_lut u_lut (
    .nibble (sel_nibble),
    .seg    (lut_seg)
  );

`ifdef SVN_SCAN_BRIGHTNESS_EN
  // Free-running PWM phase; the anode is gated, segments are not.
  logic [3:0] pwm_reg;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pwm_reg <= 4'd0;
    else            pwm_reg <= pwm_reg + 4'd1;
  end

  assign pwm_on = (pwm_reg <= bright);
`else
  assign pwm_on = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_next[gi] = ~(sel_en && pwm_on && (idx_reg == IW'(gi)));
  end

  // Output registers: one clock behind the index they were decoded from.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      an_reg         <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= sel_en ? lut_seg : SEG_OFF;
      dp_reg         <= ~(sel_en & sel_dp);
      an_reg         <= an_next;
      frame_done_reg <= wrap;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_reg;
  assign DP             = dp_reg;
  assign AN             = an_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// tb_svn_scan_ctrl: self-checking bench for svn_scan_ctrl (4 digits, CLK_DIV=4).
// A reference model derives the digit index and wrap point from the cycle
// count since reset and keeps the staging/active buffers as plain variables;
// every clock all outputs are compared against it.
module tb_svn_scan_ctrl;

  localparam int ND = 4;
  localparam int CD = 4;

  logic clk = 1'b0;
  logic sys_rst_n;
  always #5 clk = ~clk;

`ifdef SVN_SCAN_BRIGHTNESS_EN
  logic [3:0] bright;
`endif

  svn_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  logic CA, CB, CC, CD_pin, CE, CF, CG, DP;
  logic [ND-1:0] AN;

  svn_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
`ifdef SVN_SCAN_BRIGHTNESS_EN
    .bright    (bright),
`endif
    .bus       (bus),
    .CA        (CA),
    .CB        (CB),
    .CC        (CC),
    .CD        (CD_pin),
    .CE        (CE),
    .CF        (CF),
    .CG        (CG),
    .DP        (DP),
    .AN        (AN)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic       dpb;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;

  vec_t tab [16];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  longint                m_t;
  logic [4*ND-1:0]       m_stg_d, m_act_d;
  logic [ND-1:0]         m_stg_p, m_act_p, m_stg_e, m_act_e;
  bit                    m_pend;
  logic                  last_fd;

  function automatic logic [6:0] segs();
    return {CA, CB, CC, CD_pin, CE, CF, CG};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_stg_d = '0; m_act_d = '0;
    m_stg_p = '0; m_act_p = '0;
    m_stg_e = '0; m_act_e = '0;
    m_pend = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge model, compare, then advance.
  task automatic step();
    int idx;
    bit tick, wrap;
    logic [6:0] es;
    logic ed;
    logic [ND-1:0] ea;
    logic ld;
    logic [4*ND-1:0] d;
    logic [ND-1:0] p, e;
    @(posedge clk);
    ld = bus.load; d = bus.data; p = bus.dp; e = bus.digit_en;
    idx  = int'((m_t / CD) % ND);
    tick = (m_t % CD) == CD - 1;
    wrap = tick && (idx == ND - 1);
    es = 7'h7F; ed = 1'b1; ea = '1;
    if (m_act_e[idx]) begin
      es = tab[m_act_d[idx*4 +: 4]].exp_seg;
      ed = ~m_act_p[idx];
      ea[idx] = 1'b0;
`ifdef SVN_SCAN_BRIGHTNESS_EN
      if (int'(m_t % 16) > int'(bright)) ea = '1;
`endif
    end
    #1;
    check("an", AN, ea);
    check("seg", segs(), es);
    check("dp", DP, ed);
    check("frame_done", bus.frame_done, wrap);
    last_fd = bus.frame_done;
    if (wrap && m_pend) begin
      m_act_d = m_stg_d; m_act_p = m_stg_p; m_act_e = m_stg_e;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_stg_d = d; m_stg_p = p; m_stg_e = e;
      m_pend = 1'b1;
    end
    m_t++;
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic [ND-1:0] e);
    bus.data = d; bus.dp = p; bus.digit_en = e; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    $display("load data=%h dp=%b en=%b at t=%0t", d, p, e, $time);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_fd && n < 3 * ND * CD + 4);
    if (!last_fd) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, AN, {ND{1'b1}});
    check({tag, "_seg"}, segs(), 7'h7F);
    check({tag, "_dp"}, DP, 1'b1);
    check({tag, "_fd"}, bus.frame_done, 1'b0);
  endtask

  initial begin
    tab[0]  = '{4'h0, 1'b1, 7'b0000001, 1'b0};
    tab[1]  = '{4'h1, 1'b0, 7'b1001111, 1'b1};
    tab[2]  = '{4'h2, 1'b1, 7'b0010010, 1'b0};
    tab[3]  = '{4'h3, 1'b0, 7'b0000110, 1'b1};
    tab[4]  = '{4'h4, 1'b1, 7'b1001100, 1'b0};
    tab[5]  = '{4'h5, 1'b0, 7'b0100100, 1'b1};
    tab[6]  = '{4'h6, 1'b1, 7'b0100000, 1'b0};
    tab[7]  = '{4'h7, 1'b0, 7'b0001111, 1'b1};
    tab[8]  = '{4'h8, 1'b1, 7'b0000000, 1'b0};
    tab[9]  = '{4'h9, 1'b0, 7'b0000100, 1'b1};
    tab[10] = '{4'hA, 1'b1, 7'b0001000, 1'b0};
    tab[11] = '{4'hB, 1'b0, 7'b1100000, 1'b1};
    tab[12] = '{4'hC, 1'b1, 7'b0110001, 1'b0};
    tab[13] = '{4'hD, 1'b0, 7'b1000010, 1'b1};
    tab[14] = '{4'hE, 1'b1, 7'b0110000, 1'b0};
    tab[15] = '{4'hF, 1'b0, 7'b0111000, 1'b1};

    bus.data = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0;
`ifdef SVN_SCAN_BRIGHTNESS_EN
    bright = 4'd15;
`endif
    sys_rst_n = 1'b0;
    model_reset();
    #12;
    check_off("reset");
    sys_rst_n = 1'b1;

    // Decode table: every nibble shown on digit 0 after the next boundary
    for (int i = 0; i < 16; i++) begin
      do_load({ND{tab[i].nib}}, {ND{tab[i].dpb}}, {ND{1'b1}});
      wait_frame();
      step();
      check("tab_seg", segs(), tab[i].exp_seg);
      check("tab_dp", DP, tab[i].exp_dp);
      check("tab_an", AN, 4'b1110);
    end

    // Normal scan of 3210
    do_load(16'h3210, 4'b0001, 4'b1111);
    wait_frame();
    for (int k = 0; k < ND * CD; k++) begin
      logic [3:0] an_exp;
      step();
      an_exp = ~(4'b0001 << (k / CD));
      check("scan_an", AN, an_exp);
      if (k == 0) begin
        check("scan_d0_seg", segs(), 7'b0000001);
        check("scan_d0_dp", DP, 1'b0);
      end
      if (k == 3 * CD) begin
        check("scan_d3_seg", segs(), 7'b0000110);
        check("scan_d3_dp", DP, 1'b1);
      end
    end

    // Masking: digits 1 and 3 blanked
    do_load(16'h3210, 4'b0000, 4'b0101);
    wait_frame();
    for (int k = 0; k < ND * CD; k++) begin
      step();
      check("mask_an1", AN[1], 1'b1);
      check("mask_an3", AN[3], 1'b1);
      if ((k / CD) % 2 == 1) check("mask_seg", segs(), 7'h7F);
    end

    // Tear-free update; the second load before the boundary wins
    do_load(16'h3210, 4'b0000, 4'b1111);
    wait_frame();
    repeat (3) step();
    do_load(16'hFFFF, 4'b0000, 4'b1111);
    repeat (2) step();
    do_load(16'h5555, 4'b0000, 4'b1111);
    wait_frame();
    step();
    check("tear_seg", segs(), tab[5].exp_seg);

    // Load on the boundary cycle
    do_load(16'h1111, 4'b0000, 4'b1111);
    while (!((m_t % CD == CD - 1) && ((m_t / CD) % ND == ND - 1))) step();
    do_load(16'h2222, 4'b0000, 4'b1111);
    check("bnd_fd", last_fd, 1'b1);
    step();
    check("bnd_old_seg", segs(), tab[1].exp_seg);
    wait_frame();
    step();
    check("bnd_new_seg", segs(), tab[2].exp_seg);

`ifdef SVN_SCAN_BRIGHTNESS_EN
    begin
      int cnt;
      bright = 4'd3;
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (AN != 4'b1111) cnt++;
      end
      check("bright3_duty", cnt, 4);
      bright = 4'd15;
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (AN != 4'b1111) cnt++;
      end
      check("bright15_duty", cnt, 16);
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
`ifdef SVN_SCAN_BRIGHTNESS_EN
      if (n % 50 == 0) bright = 4'($urandom_range(15));
`endif
      if ($urandom_range(11) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else
        step();
    end

    // Reset mid-scan with a load still pending
    do_load(16'h4567, 4'b1010, 4'b1111);
    repeat (2) step();
    sys_rst_n = 1'b0;
    #1;
    check_off("midrst");
    #10;
    model_reset();
    sys_rst_n = 1'b1;
    repeat (3 * ND * CD) step();
    check("midrst_an", AN, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
